// File: rtl/axi_addr_remap_ctrl.sv
// axi_addr_remap_ctrl: translates AW/AR addresses through base/mask/target windows,
// holds each translation until its handshake, and commits shadow tables only when idle.
module axi_addr_remap_ctrl #(
    parameter int unsigned NumWindows   = 4,
    parameter int unsigned SlvAddrWidth = 32,
    parameter int unsigned MstAddrWidth = 32,
    parameter type slv_req_t = struct packed {
        struct packed { logic [SlvAddrWidth-1:0] addr; } aw;
        logic aw_valid;
        struct packed { logic [SlvAddrWidth-1:0] addr; } ar;
        logic ar_valid;
    },
    parameter type axi_resp_t = struct packed {
        logic aw_ready;
        logic ar_ready;
    },
    localparam int unsigned IdxW = (NumWindows > 1) ? $clog2(NumWindows) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  slv_req_t                slv_req_i,
    input  axi_resp_t               mst_resp_i,
    output logic [MstAddrWidth-1:0] mst_aw_addr_o,
    output logic [MstAddrWidth-1:0] mst_ar_addr_o,
    output logic                    aw_hit_o,
    output logic                    ar_hit_o,
    input  logic                    cfg_we_i,
    input  logic [IdxW-1:0]         cfg_idx_i,
    input  logic                    cfg_en_i,
    input  logic [SlvAddrWidth-1:0] cfg_base_i,
    input  logic [SlvAddrWidth-1:0] cfg_mask_i,
    input  logic [MstAddrWidth-1:0] cfg_target_i,
    input  logic                    cfg_commit_i,
    output logic                    commit_pending_o
);
    typedef enum logic {IDLE, HOLD} state_e;

    logic [NumWindows-1:0]   sh_en_q, act_en_q;
    logic [SlvAddrWidth-1:0] sh_base_q [NumWindows];
    logic [SlvAddrWidth-1:0] sh_mask_q [NumWindows];
    logic [MstAddrWidth-1:0] sh_tgt_q  [NumWindows];
    logic [SlvAddrWidth-1:0] act_base_q [NumWindows];
    logic [SlvAddrWidth-1:0] act_mask_q [NumWindows];
    logic [MstAddrWidth-1:0] act_tgt_q  [NumWindows];

    state_e                  state_q [2];
    state_e                  state_d [2];
    logic [MstAddrWidth-1:0] hold_addr_q [2];
    logic [MstAddrWidth-1:0] hold_addr_d [2];
    logic [MstAddrWidth-1:0] xl_addr [2];
    logic [SlvAddrWidth-1:0] slv_addr [2];
    logic [1:0]              hold_hit_q, hold_hit_d, xl_hit, valid, ready;
    logic                    pending_q, pending_d, commit;

    function automatic logic [MstAddrWidth-1:0] resize(input logic [SlvAddrWidth-1:0] a);
        return MstAddrWidth'(a);
    endfunction

    assign slv_addr[0] = slv_req_i.aw.addr;
    assign slv_addr[1] = slv_req_i.ar.addr;
    assign valid       = {slv_req_i.ar_valid, slv_req_i.aw_valid};
    assign ready       = {mst_resp_i.ar_ready, mst_resp_i.aw_ready};

    // Scan high to low so the lowest matching index overrides the rest.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            xl_addr[c] = resize(slv_addr[c]);
            xl_hit[c]  = 1'b0;
            for (int i = int'(NumWindows) - 1; i >= 0; i--) begin
                if (act_en_q[i] && ((slv_addr[c] ^ act_base_q[i]) & act_mask_q[i]) == '0) begin
                    xl_hit[c]  = 1'b1;
                    xl_addr[c] = (act_tgt_q[i] & resize(act_mask_q[i])) |
                                 (resize(slv_addr[c]) & ~resize(act_mask_q[i]));
                end
            end
        end
    end

    always_comb begin
        commit    = (pending_q | cfg_commit_i) && state_q[0] == IDLE && state_q[1] == IDLE;
        pending_d = (pending_q | cfg_commit_i) && !commit;
        for (int c = 0; c < 2; c++) begin
            state_d[c]     = state_q[c];
            hold_addr_d[c] = hold_addr_q[c];
            hold_hit_d[c]  = hold_hit_q[c];
            if (state_q[c] == IDLE) begin
                if (valid[c] && !ready[c]) begin
                    state_d[c]     = HOLD;
                    hold_addr_d[c] = xl_addr[c];
                    hold_hit_d[c]  = xl_hit[c];
                end
            end else if (!valid[c] || ready[c]) begin
                state_d[c] = IDLE;
            end
        end
    end

    assign mst_aw_addr_o    = (state_q[0] == HOLD) ? hold_addr_q[0] : xl_addr[0];
    assign aw_hit_o         = (state_q[0] == HOLD) ? hold_hit_q[0]  : xl_hit[0];
    assign mst_ar_addr_o    = (state_q[1] == HOLD) ? hold_addr_q[1] : xl_addr[1];
    assign ar_hit_o         = (state_q[1] == HOLD) ? hold_hit_q[1]  : xl_hit[1];
    assign commit_pending_o = pending_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= '{default: IDLE};
            hold_addr_q <= '{default: '0};
            hold_hit_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_hit_q  <= hold_hit_d;
            pending_q   <= pending_d;
        end
    end

    // The copy reads the shadow before this edge's write lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_en_q    <= '0;
            sh_base_q  <= '{default: '0};
            sh_mask_q  <= '{default: '0};
            sh_tgt_q   <= '{default: '0};
            act_en_q   <= '0;
            act_base_q <= '{default: '0};
            act_mask_q <= '{default: '0};
            act_tgt_q  <= '{default: '0};
        end else begin
            if (cfg_we_i && 32'(cfg_idx_i) < NumWindows) begin
                sh_en_q[cfg_idx_i]   <= cfg_en_i;
                sh_base_q[cfg_idx_i] <= cfg_base_i;
                sh_mask_q[cfg_idx_i] <= cfg_mask_i;
                sh_tgt_q[cfg_idx_i]  <= cfg_target_i;
            end
            if (commit) begin
                act_en_q   <= sh_en_q;
                act_base_q <= sh_base_q;
                act_mask_q <= sh_mask_q;
                act_tgt_q  <= sh_tgt_q;
            end
        end
    end

`ifndef SYNTHESIS
    for (genvar c = 0; c < 2; c++) begin : g_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni) state_q[c] == HOLD |-> valid[c])
            else $error("valid dropped before ready on channel %0d", c);
    end
`endif
endmodule

// File: tb/tb_axi_addr_remap_ctrl.sv
// tb_axi_addr_remap_ctrl: directed vectors feed a per-channel scoreboard that a
// negedge monitor drains whenever the channel's valid is high.
module tb_axi_addr_remap_ctrl;
    typedef struct packed { logic [31:0] addr; } ax_t;
    typedef struct packed { ax_t aw; logic aw_valid; ax_t ar; logic ar_valid; } req_t;
    typedef struct packed { logic aw_ready; logic ar_ready; } resp_t;
    typedef struct { string nm; logic [31:0] a; logic h; } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    req_t        slv_req = '0;
    resp_t       mst_resp = '0;
    logic [31:0] mst_aw_addr_o, mst_ar_addr_o;
    logic        aw_hit_o, ar_hit_o, commit_pending_o;
    logic        cfg_we_i = 1'b0, cfg_en_i = 1'b0, cfg_commit_i = 1'b0;
    logic [1:0]  cfg_idx_i = '0;
    logic [31:0] cfg_base_i = '0, cfg_mask_i = '0, cfg_target_i = '0;

    exp_t qaw[$], qar[$];
    int   n_chk = 0, n_fail = 0;

    axi_addr_remap_ctrl #(
        .NumWindows(4), .SlvAddrWidth(32), .MstAddrWidth(32),
        .slv_req_t(req_t), .axi_resp_t(resp_t)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .slv_req_i(slv_req), .mst_resp_i(mst_resp),
        .mst_aw_addr_o(mst_aw_addr_o), .mst_ar_addr_o(mst_ar_addr_o),
        .aw_hit_o(aw_hit_o), .ar_hit_o(ar_hit_o),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_en_i(cfg_en_i),
        .cfg_base_i(cfg_base_i), .cfg_mask_i(cfg_mask_i), .cfg_target_i(cfg_target_i),
        .cfg_commit_i(cfg_commit_i), .commit_pending_o(commit_pending_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        exp_t e;
        if (slv_req.aw_valid) begin
            n_chk++;
            if (qaw.size() == 0) begin
                n_fail++;
                $display("FAIL aw_unexpected: got addr=%h hit=%b, required no AW valid", mst_aw_addr_o, aw_hit_o);
            end else begin
                e = qaw.pop_front();
                if (mst_aw_addr_o !== e.a || aw_hit_o !== e.h) begin
                    n_fail++;
                    $display("FAIL %s: got addr=%h hit=%b, required addr=%h hit=%b", e.nm, mst_aw_addr_o, aw_hit_o, e.a, e.h);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (slv_req.ar_valid) begin
            n_chk++;
            if (qar.size() == 0) begin
                n_fail++;
                $display("FAIL ar_unexpected: got addr=%h hit=%b, required no AR valid", mst_ar_addr_o, ar_hit_o);
            end else begin
                e = qar.pop_front();
                if (mst_ar_addr_o !== e.a || ar_hit_o !== e.h) begin
                    n_fail++;
                    $display("FAIL %s: got addr=%h hit=%b, required addr=%h hit=%b", e.nm, mst_ar_addr_o, ar_hit_o, e.a, e.h);
                end
            end
        end
    end

    task automatic cyc(input string nm,
                       input logic awv, input logic [31:0] awa, input logic awr, input logic [31:0] eaw, input logic haw,
                       input logic arv, input logic [31:0] ara, input logic arr, input logic [31:0] ear, input logic har);
        slv_req.aw_valid = awv; slv_req.aw.addr = awa; mst_resp.aw_ready = awr;
        slv_req.ar_valid = arv; slv_req.ar.addr = ara; mst_resp.ar_ready = arr;
        if (awv) qaw.push_back('{nm: {nm, "_aw"}, a: eaw, h: haw});
        if (arv) qar.push_back('{nm: {nm, "_ar"}, a: ear, h: har});
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cyc("idle", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] idx, input logic en, input logic [31:0] b, input logic [31:0] m, input logic [31:0] t);
        cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_en_i = en; cfg_base_i = b; cfg_mask_i = m; cfg_target_i = t;
        idle();
        cfg_we_i = 1'b0;
    endtask

    task automatic commit();
        cfg_commit_i = 1'b1;
        idle();
        cfg_commit_i = 1'b0;
    endtask

    task automatic chk_pend(input string nm, input logic exp);
        n_chk++;
        if (commit_pending_o !== exp) begin
            n_fail++;
            $display("FAIL %s: got commit_pending=%b, required %b", nm, commit_pending_o, exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        cyc("rst", 1, 32'h1234_5678, 1, 32'h1234_5678, 0, 1, 32'h1234_5678, 1, 32'h1234_5678, 0);
        chk_pend("pend_rst", 1'b0);
        rst_ni = 1'b1;
        cyc("nocfg", 1, 32'h1234_5678, 1, 32'h1234_5678, 0, 1, 32'h1234_5678, 1, 32'h1234_5678, 0);

        wr(0, 1, 32'h8000_0000, 32'hF000_0000, 32'h2000_0000);
        chk_pend("pend_wr", 1'b0);
        cyc("shadow_only", 0, '0, 0, '0, 0, 1, 32'h8000_0ABC, 1, 32'h8000_0ABC, 0);
        commit();
        chk_pend("pend_idle_commit", 1'b0);
        cyc("win0_hit", 1, 32'h8FFF_FFFF, 1, 32'h2FFF_FFFF, 1, 1, 32'h8000_0ABC, 1, 32'h2000_0ABC, 1);
        cyc("win0_miss", 0, '0, 0, '0, 0, 1, 32'h9000_0000, 1, 32'h9000_0000, 0);

        wr(1, 1, 32'h8000_0000, 32'hFFFF_0000, 32'h4000_0000);
        commit();
        cyc("overlap", 1, 32'h8000_0010, 1, 32'h2000_0010, 1, 1, 32'h8000_0010, 1, 32'h2000_0010, 1);
        cfg_commit_i = 1'b1;
        wr(0, 0, 32'h8000_0000, 32'hF000_0000, 32'h2000_0000);
        cfg_commit_i = 1'b0;
        cyc("wr_commit_same", 0, '0, 0, '0, 0, 1, 32'h8000_0010, 1, 32'h2000_0010, 1);
        commit();
        cyc("win1_only", 1, 32'h8001_0000, 1, 32'h8001_0000, 0, 1, 32'h8000_0010, 1, 32'h4000_0010, 1);
        wr(0, 1, 32'h8000_0000, 32'hF000_0000, 32'h2000_0000);
        commit();

        cyc("hold0", 1, 32'h8000_0001, 0, 32'h2000_0001, 1, 0, '0, 0, '0, 0);
        for (int k = 1; k < 5; k++)
            cyc("hold", 1, 32'h9000_0000 + k, 0, 32'h2000_0001, 1, 0, '0, 0, '0, 0);
        cyc("hold_hs", 1, 32'h9000_0005, 1, 32'h2000_0001, 1, 0, '0, 0, '0, 0);
        cyc("after_hold", 1, 32'h9000_0006, 1, 32'h9000_0006, 0, 0, '0, 0, '0, 0);

        wr(0, 1, 32'h8000_0000, 32'hF000_0000, 32'h3000_0000);
        cyc("hc0", 1, 32'h8000_0002, 0, 32'h2000_0002, 1, 0, '0, 0, '0, 0);
        cfg_commit_i = 1'b1;
        cyc("hc1", 1, 32'h8000_0022, 0, 32'h2000_0002, 1, 1, 32'h8000_0004, 1, 32'h2000_0004, 1);
        cfg_commit_i = 1'b0;
        chk_pend("pend_hold", 1'b1);
        cyc("hc2", 1, 32'h8000_0033, 1, 32'h2000_0002, 1, 0, '0, 0, '0, 0);
        chk_pend("pend_hs_edge", 1'b1);
        idle();
        chk_pend("pend_applied", 1'b0);
        cyc("new_table", 1, 32'h8000_0003, 1, 32'h3000_0003, 1, 0, '0, 0, '0, 0);

        wr(0, 1, 32'h8000_0000, 32'hF000_0000, 32'h5000_0000);
        cfg_commit_i = 1'b1;
        cyc("b2b0", 1, 32'h8000_0007, 1, 32'h3000_0007, 1, 1, 32'h8000_0008, 1, 32'h3000_0008, 1);
        cfg_commit_i = 1'b0;
        chk_pend("pend_b2b", 1'b0);
        cyc("b2b1", 1, 32'h8000_0007, 1, 32'h5000_0007, 1, 1, 32'h8000_0008, 1, 32'h5000_0008, 1);

        cyc("arh0", 0, '0, 0, '0, 0, 1, 32'h8000_0005, 0, 32'h5000_0005, 1);
        cfg_commit_i = 1'b1;
        cyc("arh1", 0, '0, 0, '0, 0, 1, 32'h8000_0005, 0, 32'h5000_0005, 1);
        cfg_commit_i = 1'b0;
        chk_pend("pend_ar_hold", 1'b1);
        rst_ni = 1'b0;
        cyc("ar_rst", 0, '0, 0, '0, 0, 1, 32'h8000_0006, 0, 32'h8000_0006, 0);
        chk_pend("pend_mid_rst", 1'b0);
        rst_ni = 1'b1;
        cyc("post_rst", 1, 32'h8000_0ABC, 1, 32'h8000_0ABC, 0, 1, 32'h8000_0ABC, 1, 32'h8000_0ABC, 0);
        commit();
        cyc("shadow_clr", 1, 32'h8000_0010, 1, 32'h8000_0010, 0, 1, 32'h8000_0010, 1, 32'h8000_0010, 0);
        idle();

        n_chk++;
        if (qaw.size() != 0 || qar.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d AW and %0d AR entries left, required 0", qaw.size(), qar.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
